// File: rtl/debug_uart_rx.sv
// 8N1 serial receiver for the debug UART: a synchroniser, a single down-counter FSM and a small receive FIFO.
// The data and status outputs sit behind the top-level address decode.
module debug_uart_rx #(
  parameter int CLK_HZ     = 64_000_000,
  parameter int BIT_RATE   = 4_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_rxd,
  input  logic                          rx_pop,
  input  logic                          err_clear,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int CNT_W = $clog2(CPB);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic [1:0]       sync_r;
  logic             rxd_s;
  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  logic [7:0]       shift_r, shift_nxt_s;
  logic             push_req_s;
  logic             frame_set_s;
  logic             cnt_zero_s;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r;
  logic             full_s, pop_en_s, push_en_s, ovr_set_s;
  logic             frame_err_r, overrun_r;

  assign rxd_s      = sync_r[1];
  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  // Two-flop synchroniser for the asynchronous serial line, idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], uart_rxd};
    end
  end

  // Receiver FSM state, bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
    end
  end

  // Next-state logic; every state is timed by the one down-counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    shift_nxt_s = shift_r;
    push_req_s  = 1'b0;
    frame_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rxd_s) begin
          state_nxt_s = ST_START;
          cnt_nxt_s   = CNT_W'(CPB / 2 - 1);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else if (rxd_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
          cnt_nxt_s   = CNT_W'(CPB - 1);
          idx_nxt_s   = 3'd0;
        end
      end
      ST_DATA: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else begin
          shift_nxt_s = {rxd_s, shift_r[7:1]};
          cnt_nxt_s   = CNT_W'(CPB - 1);
          if (idx_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            idx_nxt_s = idx_r + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (!cnt_zero_s) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end else if (rxd_s) begin
          push_req_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          frame_set_s = 1'b1;
          state_nxt_s = ST_BREAK;
        end
      end
      ST_BREAK: begin
        // Held-low line: stay here so the low level cannot look like a new start bit.
        if (rxd_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BREAK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign full_s    = (count_r == (AW + 1)'(FIFO_DEPTH));
  assign pop_en_s  = rx_pop && (count_r != {(AW + 1){1'b0}});
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push_en_s = push_req_s && (!full_s || pop_en_s);
  assign ovr_set_s = push_req_s && full_s && !pop_en_s;

  // Receive FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_en_s) begin
        mem_r[wr_ptr_r] <= shift_r;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as err_clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= frame_set_s | (frame_err_r & ~err_clear);
      overrun_r   <= ovr_set_s   | (overrun_r   & ~err_clear);
    end
  end

  assign rx_valid  = (count_r != {(AW + 1){1'b0}});
  assign rx_count  = count_r;
  assign rx_data   = rx_valid ? mem_r[rd_ptr_r] : 8'h00;
  assign rx_busy   = (state_r != ST_IDLE);
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_debug_uart_rx.sv
// Self-checking bench for debug_uart_rx: directed corner cases plus random frames against a queue-based model.
module tb_debug_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_rxd;
  logic       rx_pop;
  logic       err_clear;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       exp_fe;
  logic       exp_ov;

  debug_uart_rx #(.CLK_HZ(64_000_000), .BIT_RATE(4_000_000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rxd(uart_rxd), .rx_pop(rx_pop), .err_clear(err_clear),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks, landing 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(rx_count), 32'(exp_q.size()));
    chk({tag, ".valid"}, 32'(rx_valid), 32'(exp_q.size() != 0));
    chk({tag, ".data"},  32'(rx_data),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    chk({tag, ".ferr"},  32'(frame_err), 32'(exp_fe));
    chk({tag, ".ovr"},   32'(overrun),  32'(exp_ov));
  endtask

  task automatic do_pop(input string tag);
    if (exp_q.size() != 0) chk({tag, ".head"}, 32'(rx_data), 32'(exp_q[0]));
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic do_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    exp_fe = 1'b0;
    exp_ov = 1'b0;
  endtask

  // Serial frame; optional latency probe, rx_pop or err_clear in the cycle the byte lands.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input bit lat_chk, input bit pop_at, input bit clr_at);
    bit did_pop;
    uart_rxd = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      uart_rxd = b[k];
      tick(CPB);
    end
    uart_rxd = stop_v;
    did_pop = pop_at && (exp_q.size() != 0);
    for (int i = 0; i < CPB; i++) begin
      if (i == 10) begin
        if (lat_chk) chk("latency.before", 32'(rx_valid), 32'h0);
        if (pop_at) rx_pop = 1'b1;
        if (clr_at) err_clear = 1'b1;
      end
      if (i == 11) begin
        if (lat_chk) chk("latency.at155", 32'(rx_valid), 32'h1);
        rx_pop = 1'b0;
        err_clear = 1'b0;
      end
      tick(1);
    end
    if (did_pop) void'(exp_q.pop_front());
    if (clr_at) begin
      exp_fe = 1'b0;
      exp_ov = 1'b0;
    end
    if (!stop_v) exp_fe = 1'b1;
    else if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ov = 1'b1;
  endtask

  initial begin
    logic [7:0] rb;
    rst_n = 1'b0; uart_rxd = 1'b1; rx_pop = 1'b0; err_clear = 1'b0;
    exp_fe = 1'b0; exp_ov = 1'b0;
    tick(3);
    check_model("reset");
    chk("reset.busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    tick(3);
    chk("idle.busy", 32'(rx_busy), 32'h0);

    // First byte with the 155-cycle latency probe, then pop and an empty pop.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    check_model("a5");
    do_pop("a5");
    check_model("a5.popped");
    do_pop("empty");
    check_model("empty.pop");

    // Short low glitch aborts in START.
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(6);
    chk("glitch.busy_mid", 32'(rx_busy), 32'h1);
    tick(20);
    chk("glitch.busy", 32'(rx_busy), 32'h0);
    check_model("glitch");

    // Framing error with a held-low line: one error, no re-trigger.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(20);
    chk("break.busy", 32'(rx_busy), 32'h1);
    check_model("break");
    do_clear();
    tick(19);
    check_model("break.noretrig");
    uart_rxd = 1'b1;
    tick(5);
    chk("break.exit", 32'(rx_busy), 32'h0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    check_model("after_break");
    do_pop("x11");

    // Overrun, set-wins-over-clear, then drain and clear.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    check_model("ovr");
    send_frame(8'h06, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_ov = 1'b1;
    check_model("ovr.setwins");
    for (int i = 0; i < 4; i++) do_pop("ovr.drain");
    check_model("ovr.drained");
    do_clear();
    check_model("ovr.cleared");

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 4; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE7, 1'b1, 1'b0, 1'b1, 1'b0);
    check_model("fullpp");
    for (int i = 0; i < 4; i++) do_pop("fullpp.drain");
    check_model("fullpp.empty");

    // Back-to-back frames with no idle gap.
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
    check_model("b2b");
    do_pop("b2b.first");
    do_pop("b2b.second");

    // Random frames, gaps and pops.
    for (int n = 0; n < 10; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, 1'b0, 1'b0, 1'b0);
      tick($urandom_range(0, 10));
      check_model("rand");
      if ($urandom_range(0, 2) != 0) do_pop("rand.pop");
    end

    // Reset mid-frame with a byte and an error pending.
    if (exp_q.size() == 0) send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    uart_rxd = 1'b1;
    tick(5);
    uart_rxd = 1'b0;
    tick(CPB);
    tick(44);
    rst_n = 1'b0;
    uart_rxd = 1'b1;
    #1;
    exp_q.delete();
    exp_fe = 1'b0;
    exp_ov = 1'b0;
    check_model("midrst");
    chk("midrst.busy", 32'(rx_busy), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(200);
    check_model("midrst.after");
    chk("midrst.busy_after", 32'(rx_busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
